// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants: instruction opcodes, ALU op codes, hazard
// controller state encoding and source-register usage helpers.
package hazard_ctrl_pkg;

  // Opcodes shared with the main Control unit
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation codes driven by Control
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  // Performance counter geometry
  localparam int unsigned CNT_W   = 16;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_BUBBLE = 2'b01,
    ST_FREEZE = 2'b10
  } hz_state_e;

  // True when the instruction format carries a live rs1 field
  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH: uses_rs1 = 1'b1;
      default:                                    uses_rs1 = 1'b0;
    endcase
  endfunction

  // True when the instruction format carries a live rs2 field
  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_R, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
      default:                   uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle. The pipeline side uses the master
// modport, the hazard controller the slave modport. Counter signals exist
// only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if;
  logic       IDEX_MemRead_i;
  logic [4:0] IDEX_Rd_i;
  logic [6:0] IFID_Opcode_i;
  logic [4:0] IFID_Rs1_i;
  logic [4:0] IFID_Rs2_i;
  logic       Branch_taken_i;
  logic       MemStall_i;
  logic       NoOp_o;
  logic       PCWrite_o;
  logic       IFIDWrite_o;
  logic       IFIDFlush_o;
  logic       Freeze_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] StallCnt_o;
  logic [15:0] FlushCnt_o;
`endif

  modport master (
    output IDEX_MemRead_i, IDEX_Rd_i, IFID_Opcode_i, IFID_Rs1_i, IFID_Rs2_i,
    output Branch_taken_i, MemStall_i,
    input  NoOp_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, Freeze_o
`ifdef HAZARD_PERF_CNT_EN
    , input StallCnt_o, FlushCnt_o
`endif
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_Rd_i, IFID_Opcode_i, IFID_Rs1_i, IFID_Rs2_i,
    input  Branch_taken_i, MemStall_i,
    output NoOp_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, Freeze_o
`ifdef HAZARD_PERF_CNT_EN
    , output StallCnt_o, FlushCnt_o
`endif
  );
endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// 16-bit saturating event counter (module hazard_perf_cnt), used by
// hazard_ctrl only when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt
  import hazard_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Increment on each event, sticking at the maximum value
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch IF/ID flush
// and whole-pipeline freeze on data memory stalls. All control outputs are
// combinational from the current inputs. Define HAZARD_PERF_CNT_EN to add
// saturating stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);

  hz_state_e state_d;
  hz_state_e state_q;
  logic      rs1_hit;
  logic      rs2_hit;
  logic      load_use;

  // Detect a load in EX whose destination feeds a used source of the ID
  // instruction. After a bubble the load has moved on, so a repeat bubble
  // in BUBBLE needs a fresh load (MemRead) in EX.
  always_comb begin
    rs1_hit  = uses_rs1(hz.IFID_Opcode_i) && (hz.IFID_Rs1_i == hz.IDEX_Rd_i);
    rs2_hit  = uses_rs2(hz.IFID_Opcode_i) && (hz.IFID_Rs2_i == hz.IDEX_Rd_i);
    load_use = hz.IDEX_MemRead_i && (hz.IDEX_Rd_i != 5'd0) && (rs1_hit || rs2_hit)
               && ((state_q != ST_BUBBLE) || hz.IDEX_MemRead_i);
  end

  // Prioritised hazard resolution: reset, memory stall, load-use, branch
  always_comb begin
    state_d        = ST_RUN;
    hz.NoOp_o      = 1'b0;
    hz.PCWrite_o   = 1'b1;
    hz.IFIDWrite_o = 1'b1;
    hz.IFIDFlush_o = 1'b0;
    hz.Freeze_o    = 1'b0;
    if (rst_i) begin
      hz.NoOp_o      = 1'b1;
      hz.PCWrite_o   = 1'b0;
      hz.IFIDWrite_o = 1'b0;
      state_d        = ST_RUN;
    end else if (hz.MemStall_i) begin
      hz.Freeze_o    = 1'b1;
      hz.PCWrite_o   = 1'b0;
      hz.IFIDWrite_o = 1'b0;
      state_d        = ST_FREEZE;
    end else if (load_use) begin
      // A coincident taken branch is dropped; the held ID instruction
      // resolves it again next cycle.
      hz.NoOp_o      = 1'b1;
      hz.PCWrite_o   = 1'b0;
      hz.IFIDWrite_o = 1'b0;
      state_d        = ST_BUBBLE;
    end else if (hz.Branch_taken_i) begin
      hz.IFIDFlush_o = 1'b1;
      state_d        = ST_RUN;
    end else begin
      state_d        = ST_RUN;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_ev;
  logic flush_ev;

  // Event strobes for the performance counters
  always_comb begin
    stall_ev = hz.NoOp_o || hz.Freeze_o;
    flush_ev = hz.IFIDFlush_o;
  end

  hazard_perf_cnt u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_ev),
    .cnt_o (hz.StallCnt_o)
  );

  hazard_perf_cnt u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_ev),
    .cnt_o (hz.FlushCnt_o)
  );
`endif

endmodule
